pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
- Multi-channel, double-buffered PWM generator. Successor to the single-channel LED fader.
- Drives NUM_CH outputs, e.g. R/G/B of the colour-wheel LED, from one shared period counter.
- Supports edge-aligned or center-aligned mode and a valid/ready duty-update handshake.
- New duties take effect only at a period boundary, so no output glitches mid-period.

Parameters:
- NUM_CH, 3, number of PWM channels.
- PWM_INTERVAL, 1200, counter steps per ramp (12 MHz clk -> 100 us edge-aligned period); must be >= 2.
- DW, $clog2(PWM_INTERVAL+1), duty width; allows duty = PWM_INTERVAL (100 %).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary.
- duty_in  in  NUM_CH*DW  packed duties; channel i = bits [i*DW +: DW].
- duty_valid  in  1  duty_in is valid.
- duty_ready  out  1  shadow register free.
- pwm_out  out  NUM_CH  registered PWM outputs.
- period_start  out  1  one-cycle pulse aligned with the first pwm_out cycle of each period.

Behaviour:
- Reset (rst=1 at a clk edge) gives:
  - count=0, dir=up, mode_act=0, active duty=0, shadow=0, pending=0.
  - pwm_out=0, period_start=0, duty_ready=1.
  - Reset overrides all other inputs, including mid-period and mid-handshake.
- Handshake:
  - duty_ready = !pending.
  - Transfer occurs on an edge with duty_valid & duty_ready: shadow <= duty_in, pending <= 1.
  - While duty_ready=0, duty_valid is ignored; duty_in need not be held.
- Edge-aligned counter (mode_act=0): 0,1,...,PWM_INTERVAL-1, then wraps to 0. Period = PWM_INTERVAL cycles.
- Center-aligned counter (mode_act=1):
  - Up phase 0..PWM_INTERVAL-1, then down phase PWM_INTERVAL-1..0, then up again.
  - Each endpoint value appears twice consecutively. Period = 2*PWM_INTERVAL cycles.
- Boundary: the edge on which the counter enters count=0 with dir=up, i.e. the edge that starts a new period.
  - On that edge: active <= shadow if pending, then pending <= 0.
  - On that edge: mode_act <= center_mode.
  - If a handshake transfer occurs on the same edge, the old pending value goes to active and the new value is held in shadow, pending stays 1.
- Compare (registered, 1-cycle latency): pwm_out[i] <= (count < active[i]) evaluated on the post-update count/active.
  - The first output cycle of a period therefore uses the new duty.
  - duty=0 gives constant 0. duty >= PWM_INTERVAL gives constant 1.
  - Center mode yields a pulse symmetric about the period middle, high for 2*duty cycles.
- period_start: registered; 1 in exactly the cycle whose pwm_out reflects count=0, dir=up.
- en=0:
  - Counter forced to 0, dir=up; pwm_out <= 0; period_start <= 0.
  - Pending shadow still moves to active (and center_mode is latched) on each edge.
  - Handshake remains operational.
- en 0->1: the first enabled edge is a boundary. Counting starts at 0, period_start pulses one cycle later.
- All counter and compare arithmetic is unsigned in DW bits; the counter never exceeds PWM_INTERVAL-1.

Test Plan:
- PWM_INTERVAL=8, NUM_CH=3, edge mode; load duties {0,3,8}, en=1.
  - ch0 stays 0, ch1 is high 3 of every 8 cycles, ch2 stays 1.
  - period_start pulses every 8 cycles, coincident with the ch1 rising edge.
- Mid-period (count=4) write ch1=5 while ch1=3.
  - Current period keeps a 3-cycle pulse; the next period gives a 5-cycle pulse.
  - duty_ready is 0 from the write until the boundary edge, then returns to 1.
- Second write while pending=1: duty_valid held for 3 cycles with duty_ready=0 -> no capture; shadow keeps the first value.
- Write on the exact boundary edge:
  - Active takes the previously pending value.
  - The new value applies one period later; duty_ready stays 0 across the boundary.
- center_mode=1, ch0 duty=2: period 16 cycles, with pwm_out for ch0 as follows.
  - High for the first 2 cycles (count 0,1 up).
  - Low for the middle 12 cycles.
  - High for the last 2 cycles (count 1,0 down).
  - The adjacent periods' high cycles merge into a pulse of 4 consecutive cycles centered on the period boundary.
  - Mode switches only at the boundary after center_mode changes.
- rst asserted mid-period with pending=1:
  - Next cycle: pwm_out=0, duty_ready=1, active duty=0.
  - After rst release with en=1, outputs stay 0 until a new duty is loaded and a boundary passes.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH-channel double-buffered PWM sharing one period counter.
// Edge- or center-aligned counting; duties arrive through a valid/ready
// shadow register and are promoted to the active set only on a period
// boundary, so an output never changes duty mid-period.

// Per-channel shadow/active duty pair plus the registered comparator.
module pwm_lane #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load_shadow,
  input  logic          load_active,
  input  logic [DW-1:0] duty,
  input  logic [DW-1:0] count_nx,
  output logic          pwm
);
  logic [DW-1:0] shadow, active, active_nx;

  // Promotion reads the old shadow, so a same-edge capture lands one period later.
  always_comb begin
    active_nx = load_active ? shadow : active;
  end

  // Duty registers and compare against the post-update counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (load_shadow) shadow <= duty;
      active <= active_nx;
      pwm    <= en & (count_nx < active_nx);
    end
  end
endmodule

module pwm_multi #(
  parameter int NUM_CH       = 3,
  parameter int PWM_INTERVAL = 1200,
  parameter int DW           = $clog2(PWM_INTERVAL+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 center_mode,
  input  logic [NUM_CH*DW-1:0] duty_in,
  input  logic                 duty_valid,
  output logic                 duty_ready,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic                 period_start
);
  localparam logic [DW-1:0] TOP = DW'(PWM_INTERVAL-1);

  logic [DW-1:0] count, count_nx;
  logic          dir_dn, dir_nx;   // 1 = counting down (center mode only)
  logic          mode_act;         // mode of the running period
  logic          run;              // en was high on the previous edge
  logic          pending;          // shadow holds a duty not yet promoted
  logic          boundary;         // this edge starts a new period
  logic          xfer;

  assign duty_ready = ~pending;
  assign xfer       = duty_valid & ~pending;

  // Next counter value/direction and period-boundary detection.
  always_comb begin
    count_nx = count;
    dir_nx   = dir_dn;
    boundary = 1'b0;
    if (!en || !run) begin
      // Idle, or first enabled edge: park at 0/up; every such edge is a boundary.
      count_nx = '0;
      dir_nx   = 1'b0;
      boundary = 1'b1;
    end else if (!mode_act) begin
      dir_nx = 1'b0;
      if (count == TOP) begin
        count_nx = '0;
        boundary = 1'b1;
      end else begin
        count_nx = count + DW'(1);
      end
    end else if (!dir_dn) begin
      // Top endpoint repeats once as the direction flips.
      if (count == TOP) dir_nx = 1'b1;
      else              count_nx = count + DW'(1);
    end else begin
      // Bottom endpoint repeats once; turning up again opens the next period.
      if (count == '0) begin
        dir_nx   = 1'b0;
        boundary = 1'b1;
      end else begin
        count_nx = count - DW'(1);
      end
    end
  end

  // Shared counter, mode latch, handshake flag and period-start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      dir_dn       <= 1'b0;
      mode_act     <= 1'b0;
      run          <= 1'b0;
      pending      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      count        <= count_nx;
      dir_dn       <= dir_nx;
      run          <= en;
      if (boundary) mode_act <= center_mode;
      pending      <= xfer | (pending & ~boundary);
      period_start <= en & boundary;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    pwm_lane #(.DW(DW)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .load_shadow (xfer),
      .load_active (boundary & pending),
      .duty        (duty_in[i*DW +: DW]),
      .count_nx    (count_nx),
      .pwm         (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: directed vector table, hand-written corner sequences,
// then randomized traffic against a period-position reference model.
module tb_pwm_multi;
  localparam int NUM_CH = 3;
  localparam int PI     = 8;
  localparam int DW     = $clog2(PI+1);
  localparam int DINW   = NUM_CH*DW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              center_mode = 1'b0;
  logic [DINW-1:0]   duty_in = '0;
  logic              duty_valid = 1'b0;
  logic              duty_ready;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_start;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  pwm_multi #(.NUM_CH(NUM_CH), .PWM_INTERVAL(PI)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .center_mode  (center_mode),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DINW-1:0] pk(input int c0, input int c1, input int c2);
    return {DW'(c2), DW'(c1), DW'(c0)};
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: position t within the period; count derived from t.
  int m_t = 0, m_mode = 0, m_run = 0, m_pend = 0;
  int m_sh[NUM_CH] = '{default: 0};
  int m_act[NUM_CH] = '{default: 0};
  int m_pwm = 0, m_ps = 0, m_rdy = 1;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_mode = 0; m_run = 0; m_pend = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_sh[i] = 0; m_act[i] = 0; end
      m_pwm = 0; m_ps = 0;
    end else begin
      automatic int bnd = 0;
      automatic int xf = (duty_valid && !m_pend) ? 1 : 0;
      automatic int cnt;
      if (!en || !m_run) begin
        m_t = 0; bnd = 1;
      end else begin
        m_t++;
        if (m_t == (m_mode ? 2*PI : PI)) begin m_t = 0; bnd = 1; end
      end
      m_run = en ? 1 : 0;
      if (bnd) begin
        if (m_pend) begin
          for (int i = 0; i < NUM_CH; i++) m_act[i] = m_sh[i];
          m_pend = 0;
        end
        m_mode = center_mode ? 1 : 0;
      end
      if (xf) begin
        for (int i = 0; i < NUM_CH; i++) m_sh[i] = int'(duty_in[i*DW +: DW]);
        m_pend = 1;
      end
      cnt = m_mode ? ((m_t < PI) ? m_t : 2*PI-1-m_t) : m_t;
      m_pwm = 0;
      for (int i = 0; i < NUM_CH; i++)
        if (en && cnt < m_act[i]) m_pwm |= (1 << i);
      m_ps = (en && bnd) ? 1 : 0;
    end
    m_rdy = m_pend ? 0 : 1;
  end

  // Continuous comparison of the DUT against the model.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("model_pwm", int'(pwm_out), m_pwm);
      chk("model_ps", int'(period_start), m_ps);
      chk("model_rdy", int'(duty_ready), m_rdy);
    end
  end

  typedef struct {
    logic       rst, en, cm, vld;
    int         d0, d1, d2;
    logic [2:0] pwm;
    logic       ps, rdy;
  } vec_t;
  vec_t tbl[12];

  // Sum of pwm_out bits over n samples (current one plus n-1 further cycles).
  task automatic count_high(input int mask, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      if (k != 0) tick();
      hi += $countones(int'(pwm_out) & mask);
    end
  endtask

  task automatic wait_ps(input int limit, input string nm);
    int k = 0;
    while (!period_start && k < limit) begin tick(); k++; end
    chk({nm, "_ps_seen"}, int'(period_start), 1);
  endtask

  initial begin
    int hi;
    logic [15:0] pat;

    //           rst  en  cm  vld d0 d1 d2  pwm     ps  rdy
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b1,0,3,8, 3'b000,1'b0,1'b1};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b1,0,3,8, 3'b000,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,0,3,8, 3'b000,1'b0,1'b1};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,0,3,8, 3'b110,1'b1,1'b1};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,0,3,8, 3'b110,1'b0,1'b1};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,0,3,8, 3'b110,1'b0,1'b1};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,0,3,8, 3'b100,1'b0,1'b1};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,0,3,8, 3'b100,1'b0,1'b1};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,0,3,8, 3'b100,1'b0,1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,0,3,8, 3'b100,1'b0,1'b1};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,0,3,8, 3'b100,1'b0,1'b1};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b0,0,3,8, 3'b110,1'b1,1'b1};

    tick();
    for (int v = 0; v < 12; v++) begin
      rst = tbl[v].rst; en = tbl[v].en; center_mode = tbl[v].cm;
      duty_valid = tbl[v].vld; duty_in = pk(tbl[v].d0, tbl[v].d1, tbl[v].d2);
      tick();
      chk_on = 1'b1;
      chk($sformatf("vec%0d_pwm", v), int'(pwm_out), int'(tbl[v].pwm));
      chk($sformatf("vec%0d_ps", v), int'(period_start), int'(tbl[v].ps));
      chk($sformatf("vec%0d_rdy", v), int'(duty_ready), int'(tbl[v].rdy));
    end

    // Mid-period write at count 4, then a second write ignored while pending.
    repeat (4) tick();
    duty_in = pk(0, 5, 8); duty_valid = 1'b1;
    tick();
    chk("midwrite_rdy", int'(duty_ready), 0);
    duty_in = pk(0, 7, 8);
    tick(); chk("hold1_rdy", int'(duty_ready), 0);
    tick(); chk("hold2_rdy", int'(duty_ready), 0);
    tick();
    duty_valid = 1'b0;
    chk("bnd_ps", int'(period_start), 1);
    chk("bnd_rdy", int'(duty_ready), 1);
    count_high(2, PI, hi);
    chk("ch1_dut5_high", hi, 5);

    // Write landing on the boundary edge: applies one period later.
    duty_in = pk(0, 2, 8); duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    chk("bwrite_ps", int'(period_start), 1);
    chk("bwrite_rdy", int'(duty_ready), 0);
    count_high(2, PI, hi);
    chk("bwrite_old_high", hi, 5);
    tick();
    chk("bwrite_rdy_back", int'(duty_ready), 1);
    count_high(2, PI, hi);
    chk("bwrite_new_high", hi, 2);

    // Center mode with ch0 duty 2.
    center_mode = 1'b1;
    duty_in = pk(2, 0, 0); duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    tick();
    wait_ps(4*PI, "center");
    pat = '0;
    for (int k = 0; k < 2*PI; k++) begin
      if (k != 0) tick();
      pat = {pat[14:0], pwm_out[0]};
    end
    chk("center_pattern", int'(pat), 16'hC003);
    tick();
    chk("center_period_ps", int'(period_start), 1);
    chk("center_merge_ch0", int'(pwm_out[0]), 1);

    // Reset mid-period with a pending duty.
    duty_in = pk(5, 5, 5); duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    chk("pre_rst_rdy", int'(duty_ready), 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_rdy", int'(duty_ready), 1);
    chk("rst_ps", int'(period_start), 0);
    rst = 1'b0; en = 1'b1; center_mode = 1'b0;
    tick();
    count_high(7, 20, hi);
    chk("post_rst_quiet", hi, 0);

    // Randomized traffic; the model checker compares every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      en  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 63) == 0) center_mode = ~center_mode;
      duty_valid = ($urandom_range(0, 3) == 0);
      duty_in = DINW'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
